pipeline_hazard_ctrl: RTL

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 40 ++++
 rtl/pipeline_hazard_ctrl_if.sv | 51 +++++
 rtl/pipeline_hazard_ctrl_forwarding_unit.sv | 34 +++
 rtl/pipeline_hazard_ctrl.sv | 137 +++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package Pipe_Buf_Reg_PKG;

    localparam int unsigned REG_W   = 5;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned DRAIN_W = 2;

    localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(2);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_DRAIN    = 2'b10,
        ST_HALTED   = 2'b11
    } hz_state_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    // Pipeline register enables and flushes driven by the controller.
    typedef struct packed {
        logic pc_write;
        logic pc_sel;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_write;
        logic id_ex_flush;
        logic ex_mem_write;
        logic mem_wb_write;
    } pipe_ctrl_t;

    // Saturating event counter increment.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bundle: pipeline field inputs and control/forwarding outputs.
interface pipeline_hazard_ctrl_if;
    import Pipe_Buf_Reg_PKG::*;

    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic [REG_W-1:0] ex_rs1;
    logic [REG_W-1:0] ex_rs2;
    logic [REG_W-1:0] ex_rd;
    logic             ex_memread;
    logic             ex_regwrite;
    logic             ex_halt;
    logic             ex_redirect;
    logic [REG_W-1:0] mem_rd;
    logic             mem_regwrite;
    logic             mem_access;
    logic [REG_W-1:0] wb_rd;
    logic             wb_regwrite;
    logic             dmem_ready;

    logic             pc_write;
    logic             pc_sel;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_write;
    logic             id_ex_flush;
    logic             ex_mem_write;
    logic             mem_wb_write;
    fwd_sel_e         fwd_a;
    fwd_sel_e         fwd_b;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd,
        output ex_memread, ex_regwrite, ex_halt, ex_redirect,
        output mem_rd, mem_regwrite, mem_access, wb_rd, wb_regwrite, dmem_ready,
        input  pc_write, pc_sel, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
        input  ex_mem_write, mem_wb_write, fwd_a, fwd_b, halted, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd,
        input  ex_memread, ex_regwrite, ex_halt, ex_redirect,
        input  mem_rd, mem_regwrite, mem_access, wb_rd, wb_regwrite, dmem_ready,
        output pc_write, pc_sel, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
        output ex_mem_write, mem_wb_write, fwd_a, fwd_b, halted, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_forwarding_unit.sv
// EX-stage operand forwarding select; the MEM-stage result wins over WB.
module forwarding_unit
    import Pipe_Buf_Reg_PKG::*;
(
    input  logic [REG_W-1:0] ex_rs1_i,
    input  logic [REG_W-1:0] ex_rs2_i,
    input  logic [REG_W-1:0] mem_rd_i,
    input  logic             mem_regwrite_i,
    input  logic [REG_W-1:0] wb_rd_i,
    input  logic             wb_regwrite_i,
    output fwd_sel_e         fwd_a_o,
    output fwd_sel_e         fwd_b_o
);

    // x0 is never forwarded since it always reads as zero.
    function automatic fwd_sel_e pick(
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] mem_rd,
        input logic             mem_we,
        input logic [REG_W-1:0] wb_rd,
        input logic             wb_we
    );
        if (mem_we && (mem_rd != '0) && (mem_rd == rs)) return FWD_MEM;
        if (wb_we && (wb_rd != '0) && (wb_rd == rs))    return FWD_WB;
        return FWD_RF;
    endfunction

    // Independent select per source operand.
    always_comb begin
        fwd_a_o = pick(ex_rs1_i, mem_rd_i, mem_regwrite_i, wb_rd_i, wb_regwrite_i);
        fwd_b_o = pick(ex_rs2_i, mem_rd_i, mem_regwrite_i, wb_rd_i, wb_regwrite_i);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush/halt sequencing plus event counters.
module pipeline_hazard_ctrl
    import Pipe_Buf_Reg_PKG::*;
(
    input  logic                  clk,
    input  logic                  reset,
    pipeline_hazard_ctrl_if.slave hz
);

    hz_state_e          state_q, state_d;
    hz_state_e          ret_q, ret_d;
    hz_state_e          cur_state_c;
    hz_state_e          eff_state_c;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic               halted_q;
    pipe_ctrl_t         ctrl_c;
    logic               freeze_c;
    logic               load_use_c;
    logic               stall_c;
    logic               redirect_ok_c;
    logic               unused_ok_c;

    // EX-stage register write enable does not affect hazard decisions.
    assign unused_ok_c = hz.ex_regwrite;

    // Operand forwarding, independent of controller state.
    forwarding_unit u_fwd (
        .ex_rs1_i       (hz.ex_rs1),
        .ex_rs2_i       (hz.ex_rs2),
        .mem_rd_i       (hz.mem_rd),
        .mem_regwrite_i (hz.mem_regwrite),
        .wb_rd_i        (hz.wb_rd),
        .wb_regwrite_i  (hz.wb_regwrite),
        .fwd_a_o        (hz.fwd_a),
        .fwd_b_o        (hz.fwd_b)
    );

    // Next-state, control outputs and counter updates; reset cycle behaves as RUN.
    always_comb begin
        ctrl_c        = '{pc_write: 1'b1, pc_sel: 1'b0, if_id_write: 1'b1, if_id_flush: 1'b0,
                          id_ex_write: 1'b1, id_ex_flush: 1'b0, ex_mem_write: 1'b1,
                          mem_wb_write: 1'b1};
        cur_state_c   = reset ? ST_RUN : state_q;
        eff_state_c   = cur_state_c;
        state_d       = cur_state_c;
        ret_d         = reset ? ST_RUN : ret_q;
        drain_d       = drain_q;
        stall_c       = 1'b0;
        redirect_ok_c = 1'b0;

        freeze_c   = (hz.mem_access && !hz.dmem_ready) ||
                     ((cur_state_c == ST_MEM_WAIT) && !hz.dmem_ready);
        load_use_c = hz.ex_memread && (hz.ex_rd != '0) &&
                     ((hz.ex_rd == hz.id_rs1) || (hz.ex_rd == hz.id_rs2));

        // A released MEM_WAIT acts as the state it interrupted this very cycle.
        if (cur_state_c == ST_MEM_WAIT) begin
            eff_state_c = ret_q;
        end

        if (cur_state_c == ST_HALTED) begin
            ctrl_c = '0;
        end else if (freeze_c) begin
            ctrl_c  = '0;
            stall_c = 1'b1;
            if (cur_state_c != ST_MEM_WAIT) begin
                ret_d   = cur_state_c;
                state_d = ST_MEM_WAIT;
            end
        end else begin
            state_d = eff_state_c;
            if (eff_state_c == ST_DRAIN) begin
                ctrl_c.pc_write    = 1'b0;
                ctrl_c.if_id_flush = 1'b1;
                ctrl_c.id_ex_flush = 1'b1;
                if (drain_q == '0) begin
                    state_d = ST_HALTED;
                end else begin
                    drain_d = drain_q - DRAIN_W'(1);
                end
            end else if (hz.ex_halt) begin
                ctrl_c.pc_write    = 1'b0;
                ctrl_c.if_id_flush = 1'b1;
                ctrl_c.id_ex_flush = 1'b1;
                state_d            = ST_DRAIN;
                drain_d            = DRAIN_INIT;
            end else if (hz.ex_redirect) begin
                ctrl_c.pc_sel      = 1'b1;
                ctrl_c.if_id_flush = 1'b1;
                ctrl_c.id_ex_flush = 1'b1;
                redirect_ok_c      = 1'b1;
            end else if (load_use_c) begin
                ctrl_c.pc_write    = 1'b0;
                ctrl_c.if_id_write = 1'b0;
                ctrl_c.id_ex_flush = 1'b1;
                stall_c            = 1'b1;
            end
        end

        stall_cnt_d = stall_c       ? sat_inc(stall_cnt_q) : stall_cnt_q;
        flush_cnt_d = redirect_ok_c ? sat_inc(flush_cnt_q) : flush_cnt_q;
    end

    // State, drain counter, event counters and halted flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            ret_q       <= ST_RUN;
            drain_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            drain_q     <= drain_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            halted_q    <= (state_d == ST_HALTED);
        end
    end

    assign hz.pc_write     = ctrl_c.pc_write;
    assign hz.pc_sel       = ctrl_c.pc_sel;
    assign hz.if_id_write  = ctrl_c.if_id_write;
    assign hz.if_id_flush  = ctrl_c.if_id_flush;
    assign hz.id_ex_write  = ctrl_c.id_ex_write;
    assign hz.id_ex_flush  = ctrl_c.id_ex_flush;
    assign hz.ex_mem_write = ctrl_c.ex_mem_write;
    assign hz.mem_wb_write = ctrl_c.mem_wb_write;
    assign hz.halted       = halted_q;
    assign hz.stall_cnt    = stall_cnt_q;
    assign hz.flush_cnt    = flush_cnt_q;

endmodule
